// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bundle for the memory-access stage.
// The master drives EX-side controls; the slave (mem_stage) drives the registered outputs.
interface mem_stage_if;
  logic        exMemRead;
  logic        exMemWrite;
  logic        exMemtoReg;
  logic        exRegWrite;
  logic [31:0] exALUresult;
  logic [31:0] exWriteData;
  logic [4:0]  exWriteReg;
  logic [1:0]  exSize;
  logic        exUnsigned;
  logic        stall;
  logic        flush;

  logic [31:0] memReaddata;
  logic [31:0] memALUresult;
  logic        MemtoReg;
  logic        memRegWrite;
  logic [4:0]  memWriteReg;
  logic        misalign;

  modport master (
    output exMemRead, exMemWrite, exMemtoReg, exRegWrite, exALUresult,
           exWriteData, exWriteReg, exSize, exUnsigned, stall, flush,
    input  memReaddata, memALUresult, MemtoReg, memRegWrite, memWriteReg, misalign
  );

  modport slave (
    input  exMemRead, exMemWrite, exMemtoReg, exRegWrite, exALUresult,
           exWriteData, exWriteReg, exSize, exUnsigned, stall, flush,
    output memReaddata, memALUresult, MemtoReg, memRegWrite, memWriteReg, misalign
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: little-endian byte/half/word access to a word-addressed
// data memory, with results registered into the MEM/WB register.
module mem_stage #(
  parameter int unsigned ADDR_BITS = 8
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [31:0]          mem [DEPTH];

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic                 is_byte;
  logic                 is_half;
  logic                 is_word;
  logic                 misaligned;
  logic [31:0]          rd_word;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [31:0]          load_val;
  logic [31:0]          load_data;
  logic [3:0]           byte_en;
  logic [31:0]          store_data;
  logic                 store_en;

  assign word_idx = bus.exALUresult[ADDR_BITS+1:2];
  assign lane     = bus.exALUresult[1:0];
  assign is_byte  = (bus.exSize == 2'b00);
  assign is_half  = (bus.exSize == 2'b01);
  assign is_word  = bus.exSize[1];

  assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));

  // Read port sees pre-store contents, so a same-cycle read+write returns old data.
  assign rd_word = mem[word_idx];

  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      2'd3: byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
  end

  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    if (is_byte) begin
      load_val = {{24{!bus.exUnsigned && byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_val = {{16{!bus.exUnsigned && half_sel[15]}}, half_sel};
    end
  end

  assign load_data = (bus.exMemRead && !misaligned) ? load_val : '0;

  // Narrow store data is replicated across lanes; byte_en picks the live lanes.
  always_comb begin
    byte_en    = '0;
    store_data = bus.exWriteData;
    if (is_byte) begin
      byte_en[lane] = 1'b1;
      store_data    = {4{bus.exWriteData[7:0]}};
    end else if (is_half) begin
      byte_en    = lane[1] ? 4'b1100 : 4'b0011;
      store_data = {2{bus.exWriteData[15:0]}};
    end else begin
      byte_en    = '1;
    end
  end

  assign store_en = bus.exMemWrite && !misaligned && !bus.stall && !bus.flush;

  // Memory is never cleared; the rst term only blocks commits while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && store_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.memReaddata  <= '0;
      bus.memALUresult <= '0;
      bus.MemtoReg     <= 1'b0;
      bus.memRegWrite  <= 1'b0;
      bus.memWriteReg  <= '0;
      bus.misalign     <= 1'b0;
    end else if (bus.flush) begin
      bus.memReaddata  <= '0;
      bus.memALUresult <= '0;
      bus.MemtoReg     <= 1'b0;
      bus.memRegWrite  <= 1'b0;
      bus.memWriteReg  <= '0;
      bus.misalign     <= 1'b0;
    end else if (!bus.stall) begin
      bus.memReaddata  <= load_data;
      bus.memALUresult <= bus.exALUresult;
      bus.MemtoReg     <= bus.exMemtoReg;
      bus.memRegWrite  <= bus.exRegWrite;
      bus.memWriteReg  <= bus.exWriteReg;
      bus.misalign     <= misaligned && (bus.exMemRead || bus.exMemWrite);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed accesses push expected MEM/WB
// contents; a monitor compares them one cycle after each issue.
module tb_mem_stage;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic        mtr;
    logic        rw;
    logic [4:0]  wreg;
    logic        mis;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb_q[$];
  exp_t last;
  logic [4:0] tag;

  mem_stage_if bus ();

  mem_stage #(.ADDR_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tagname, input exp_t e);
    chk({tagname, ".memReaddata"},  bus.memReaddata,  e.rd);
    chk({tagname, ".memALUresult"}, bus.memALUresult, e.alu);
    chk({tagname, ".MemtoReg"},     {31'd0, bus.MemtoReg},    {31'd0, e.mtr});
    chk({tagname, ".memRegWrite"},  {31'd0, bus.memRegWrite}, {31'd0, e.rw});
    chk({tagname, ".memWriteReg"},  {27'd0, bus.memWriteReg}, {27'd0, e.wreg});
    chk({tagname, ".misalign"},     {31'd0, bus.misalign},    {31'd0, e.mis});
  endtask

  // One access per cycle; loads also drive MemtoReg/RegWrite so pass-through is visible.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic st, input logic fl,
                       input logic [31:0] exp_rd, input logic exp_mis);
    exp_t e;
    @(negedge clk);
    tag = tag + 5'd1;
    bus.exMemRead   = rd;
    bus.exMemWrite  = wr;
    bus.exMemtoReg  = rd;
    bus.exRegWrite  = rd;
    bus.exALUresult = addr;
    bus.exWriteData = wd;
    bus.exWriteReg  = tag;
    bus.exSize      = sz;
    bus.exUnsigned  = uns;
    bus.stall       = st;
    bus.flush       = fl;
    if (fl) begin
      e = '{32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0};
    end else if (st) begin
      e = last;
    end else begin
      e = '{exp_rd, addr, rd, rd, tag, exp_mis};
    end
    last = e;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_outputs("sb", e);
      end
    end
  end

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;

  initial begin
    exp_t z;
    z     = '{32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0};
    total = 0;
    bad   = 0;
    tag   = 5'd0;
    last  = z;
    rst   = 1'b0;
    bus.exMemRead   = 1'b0;
    bus.exMemWrite  = 1'b0;
    bus.exMemtoReg  = 1'b0;
    bus.exRegWrite  = 1'b0;
    bus.exALUresult = '0;
    bus.exWriteData = '0;
    bus.exWriteReg  = '0;
    bus.exSize      = '0;
    bus.exUnsigned  = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;

    #3 chk_outputs("reset_hold", z);

    // Non-zero outputs, then reset asserted between edges.
    rst = 1'b1;
    issue(1'b0, 1'b0, W, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_outputs("async_reset", z);
    rst  = 1'b1;
    last = z;
    issue(1'b0, 1'b0, W, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Word store/load and index wrap-around
    issue(1'b0, 1'b1, W, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, W, 1'b0, 32'h10,  32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b0, W, 1'b0, 32'h410, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte/half extraction and narrow store
    issue(1'b1, 1'b0, B, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0, 32'hFFFFFFBE, 1'b0);
    issue(1'b1, 1'b0, B, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0, 32'h000000BE, 1'b0);
    issue(1'b0, 1'b1, B, 1'b0, 32'h13, 32'hFFFFFF00, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h00ADBEEF, 1'b0);
    issue(1'b1, 1'b0, H, 1'b0, 32'h12, 32'h0, 1'b0, 1'b0, 32'h000000AD, 1'b0);
    issue(1'b1, 1'b0, H, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hFFFFBEEF, 1'b0);

    // Misalignment
    issue(1'b0, 1'b1, W, 1'b0, 32'h20, 32'h11111111, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, W, 1'b0, 32'h21, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 1'b0, W, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h11111111, 1'b0);
    issue(1'b1, 1'b0, H, 1'b0, 32'h23, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Stall: held outputs, suppressed store, then commit on release
    issue(1'b0, 1'b1, W, 1'b0, 32'h30, 32'h01020304, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, W, 1'b0, 32'h30, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, W, 1'b0, 32'h30, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, W, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h01020304, 1'b0);
    issue(1'b0, 1'b1, W, 1'b0, 32'h30, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 1'b1, W, 1'b0, 32'h30, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, W, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0);

    // Flush beats stall and blocks the store
    issue(1'b1, 1'b1, W, 1'b0, 32'h30, 32'h77777777, 1'b1, 1'b1, 32'h0, 1'b0);
    issue(1'b1, 1'b0, W, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0);

    // Back-to-back and same-cycle read+write
    issue(1'b0, 1'b1, W, 1'b0, 32'h40, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, W, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h5, 1'b0);
    issue(1'b1, 1'b1, W, 1'b0, 32'h40, 32'h9, 1'b0, 1'b0, 32'h5, 1'b0);
    issue(1'b1, 1'b0, W, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h9, 1'b0);

    // Halfword store into the upper lanes; size 11 behaves as word
    issue(1'b0, 1'b1, H, 1'b0, 32'h42, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h56780009, 1'b0);
    issue(1'b1, 1'b0, H, 1'b1, 32'h42, 32'h0, 1'b0, 1'b0, 32'h00005678, 1'b0);
    issue(1'b1, 1'b0, B, 1'b0, 32'h43, 32'h0, 1'b0, 1'b0, 32'h00000056, 1'b0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
